// File: rtl/conv_encoder_k7.sv
// Rate-1/2, K=7 convolutional encoder with a registered output stage.
// Define CONV_ENC_TAIL_EN to terminate each FRAME_LEN-bit frame with 6 zero tail bits.
module conv_encoder_k7 #(
   parameter logic [6:0]  G0        = 7'o171,
   parameter logic [6:0]  G1        = 7'o133,
   parameter int unsigned FRAME_LEN = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_bit,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [1:0] tx_pair,
   output logic       out_last
);

   if (FRAME_LEN == 0 || FRAME_LEN > 65535) begin : gen_frame_len_check
      $error("conv_encoder_k7: FRAME_LEN must be in 1..65535");
   end

   logic [5:0] sr_q, sr_d;
   logic [1:0] pair_q, pair_d;
   logic       valid_q, valid_d;
   logic       free, encode, u;
   logic [6:0] r;

   // The encoder only advances when the output register can take a new pair.
   assign free = !valid_q || out_ready;

`ifdef CONV_ENC_TAIL_EN
   typedef enum logic [0:0] {StData, StTail} state_e;

   localparam logic [15:0] LastBit = 16'(FRAME_LEN - 1);

   state_e      state_q, state_d;
   logic [15:0] bit_cnt_q, bit_cnt_d;
   logic [2:0]  tail_cnt_q, tail_cnt_d;
   logic        last_q, last_d, last_new;

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      tail_cnt_d = tail_cnt_q;
      encode     = 1'b0;
      u          = 1'b0;
      last_new   = 1'b0;
      in_ready   = 1'b0;
      unique case (state_q)
         StData: begin
            in_ready = free && rst_n;
            if (in_valid && in_ready) begin
               encode = 1'b1;
               u      = in_bit;
               if (bit_cnt_q == LastBit) begin
                  bit_cnt_d = '0;
                  state_d   = StTail;
               end else begin
                  bit_cnt_d = bit_cnt_q + 16'd1;
               end
            end
         end
         StTail: begin
            if (free) begin
               encode = 1'b1;
               if (tail_cnt_q == 3'd5) begin
                  tail_cnt_d = '0;
                  last_new   = 1'b1;
                  state_d    = StData;
               end else begin
                  tail_cnt_d = tail_cnt_q + 3'd1;
               end
            end
         end
         default: state_d = StData;
      endcase
      last_d = encode ? last_new : last_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StData;
         bit_cnt_q  <= '0;
         tail_cnt_q <= '0;
         last_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         tail_cnt_q <= tail_cnt_d;
         last_q     <= last_d;
      end
   end

   assign out_last = last_q;
`else
   assign in_ready = free && rst_n;
   assign encode   = in_valid && in_ready;
   assign u        = in_bit;
   assign out_last = 1'b0;
`endif

   always_comb begin
      sr_d    = sr_q;
      pair_d  = pair_q;
      valid_d = valid_q;
      r       = {u, sr_q};
      if (encode) begin
         pair_d  = {^(r & G1), ^(r & G0)};
         sr_d    = {u, sr_q[5:1]};
         valid_d = 1'b1;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q    <= '0;
         pair_q  <= 2'b00;
         valid_q <= 1'b0;
      end else begin
         sr_q    <= sr_d;
         pair_q  <= pair_d;
         valid_q <= valid_d;
      end
   end

   assign tx_pair   = pair_q;
   assign out_valid = valid_q;

endmodule
